// File: rtl/nvdla_csb_sequencer_pkg.sv
// Shared types for the NVDLA CSB command-list sequencer: command opcodes,
// the latched command record and the sequencer state encoding.
package nvdla_csb_sequencer_pkg;

   localparam int unsigned CSB_ADDR_W = 16;
   localparam int unsigned CSB_DATA_W = 32;

   typedef enum logic [1:0] {
      OP_WRITE     = 2'd0,
      OP_READ      = 2'd1,
      OP_POLL      = 2'd2,
      OP_WAIT_INTR = 2'd3
   } csb_seq_op_e;

   typedef struct packed {
      csb_seq_op_e             op;
      logic [CSB_ADDR_W-1:0]   addr;
      logic [CSB_DATA_W-1:0]   data;
      logic [CSB_DATA_W-1:0]   mask;
      logic                    last;
   } csb_seq_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_POLL_GAP,
      ST_WAIT_INTR,
      ST_FINISH,
      ST_ERROR
   } csb_seq_state_e;

   // Retired-command counter sticks at its maximum instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/nvdla_csb_sequencer_timer.sv
// Loadable down-counter used for the poll re-read gap and the watchdog.
// Load wins over count; the counter holds at zero.
module nvdla_csb_seq_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (load_i) begin
         cnt_o <= load_val_i;
      end else if (en_i && (cnt_o != '0)) begin
         cnt_o <= cnt_o - W'(1);
      end
   end

endmodule

// File: rtl/nvdla_csb_sequencer.sv
// NVDLA CSB command-list sequencer: fetches WRITE/READ/POLL/WAIT_INTR commands
// and drives them onto the CSB one at a time. Define NVDLA_CSB_SEQ_TIMEOUT_EN for the watchdog.
module nvdla_csb_sequencer
   import nvdla_csb_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W    = CSB_ADDR_W,
   parameter int unsigned DATA_W    = CSB_DATA_W,
   parameter int unsigned POLL_GAP  = 8,
   parameter int unsigned TIMEOUT_W = 20
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   input  logic [DATA_W-1:0] cmd_mask_i,
   input  logic              cmd_last_i,
   output logic              csb_valid_o,
   input  logic              csb_ready_i,
   output logic [ADDR_W-1:0] csb_addr_o,
   output logic [DATA_W-1:0] csb_wdat_o,
   output logic              csb_write_o,
   output logic              csb_nposted_o,
   input  logic              csb_rvalid_i,
   input  logic [DATA_W-1:0] csb_rdata_i,
   input  logic              csb_wr_complete_i,
   input  logic              intr_i,
   output logic              rd_valid_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [15:0]       cmd_cnt_o
);

   localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);

   csb_seq_state_e    state_q, state_d;
   csb_seq_cmd_t      cmd_q;
   logic              srst;
   logic              retire;
   logic              rsp_hit;
   logic              poll_match;
   logic              unexpected;
   logic              tmo_fire;
   logic [GAP_W-1:0]  gap_cnt;
   logic [15:0]       cnt_q;
   logic              err_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;

   assign srst = rst_i | clear_i;

   assign rsp_hit    = (cmd_q.op == OP_WRITE) ? csb_wr_complete_i : csb_rvalid_i;
   assign poll_match = ((csb_rdata_i ^ DATA_W'(cmd_q.data)) & DATA_W'(cmd_q.mask)) == '0;
   // Responses in WAIT_RSP are expected; in ERROR they belong to an abandoned request.
   assign unexpected = (csb_rvalid_i | csb_wr_complete_i) &&
                       !(state_q inside {ST_IDLE, ST_WAIT_RSP, ST_ERROR});

   nvdla_csb_seq_timer #(.W(GAP_W)) u_gap (
      .clk_i      (clk_i),
      .rst_i      (srst),
      .load_i     (state_q == ST_WAIT_RSP),
      .load_val_i (GAP_W'(POLL_GAP - 1)),
      .en_i       (state_q == ST_POLL_GAP),
      .cnt_o      (gap_cnt)
   );

`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
   logic                 tmo_run;
   logic [TIMEOUT_W-1:0] tmo_cnt;

   assign tmo_run = state_q inside {ST_ISSUE, ST_WAIT_RSP, ST_POLL_GAP, ST_WAIT_INTR};

   // Reloaded whenever no command is in flight, so every retire restarts it.
   nvdla_csb_seq_timer #(.W(TIMEOUT_W)) u_tmo (
      .clk_i      (clk_i),
      .rst_i      (srst),
      .load_i     (!tmo_run),
      .load_val_i ('1),
      .en_i       (tmo_run),
      .cnt_o      (tmo_cnt)
   );

   assign tmo_fire = tmo_run && (tmo_cnt == TIMEOUT_W'(1));
`else
   assign tmo_fire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      unique case (state_q)
         ST_IDLE:      if (start_i) state_d = ST_FETCH;
         ST_FETCH: begin
            if (cmd_valid_i) begin
               state_d = (csb_seq_op_e'(cmd_op_i) == OP_WAIT_INTR) ? ST_WAIT_INTR : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (tmo_fire)         state_d = ST_ERROR;
            else if (csb_ready_i) state_d = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (rsp_hit) begin
               if ((cmd_q.op == OP_POLL) && !poll_match) state_d = ST_POLL_GAP;
               else                                      retire  = 1'b1;
            end else if (tmo_fire) begin
               state_d = ST_ERROR;
            end
         end
         ST_POLL_GAP: begin
            if (tmo_fire)              state_d = ST_ERROR;
            else if (gap_cnt == '0)    state_d = ST_ISSUE;
         end
         ST_WAIT_INTR: begin
            if (intr_i)        retire  = 1'b1;
            else if (tmo_fire) state_d = ST_ERROR;
         end
         ST_FINISH:    state_d = ST_IDLE;
         ST_ERROR:     if (cmd_valid_i && cmd_last_i) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
      if (retire) state_d = cmd_q.last ? ST_FINISH : ST_FETCH;
   end

   always_ff @(posedge clk_i) begin
      if (srst) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= 1'b0;
         if ((state_q == ST_FETCH) && cmd_valid_i) begin
            cmd_q.op   <= csb_seq_op_e'(cmd_op_i);
            cmd_q.addr <= CSB_ADDR_W'(cmd_addr_i);
            cmd_q.data <= CSB_DATA_W'(cmd_data_i);
            cmd_q.mask <= CSB_DATA_W'(cmd_mask_i);
            cmd_q.last <= cmd_last_i;
         end
         if ((state_q == ST_IDLE) && start_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
         end else if (retire) begin
            cnt_q <= sat_inc16(cnt_q);
         end
         if ((state_q == ST_WAIT_RSP) && csb_rvalid_i && (cmd_q.op == OP_READ)) begin
            rd_data_q  <= csb_rdata_i;
            rd_valid_q <= 1'b1;
         end
         if (unexpected || ((state_q != ST_ERROR) && (state_d == ST_ERROR))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign cmd_ready_o   = (state_q == ST_FETCH) || (state_q == ST_ERROR);
   assign csb_valid_o   = (state_q == ST_ISSUE);
   assign csb_addr_o    = csb_valid_o ? ADDR_W'(cmd_q.addr) : '0;
   assign csb_wdat_o    = csb_valid_o ? DATA_W'(cmd_q.data) : '0;
   assign csb_write_o   = csb_valid_o && (cmd_q.op == OP_WRITE);
   assign csb_nposted_o = csb_write_o;
   assign rd_valid_o    = rd_valid_q;
   assign rd_data_o     = rd_data_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = (state_q == ST_FINISH);
   assign err_o         = err_q;
   assign cmd_cnt_o     = cnt_q;

endmodule
